// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
package data_cache_pkg;

   localparam int unsigned WORD_BITS        = 32;
   localparam int unsigned BYTE_OFFSET_BITS = 2;

   // Controller states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_WRITE_BACK,
      ST_ALLOCATE,
      ST_WAIT_FILL
   } state_t;

   // Tag width left over once byte offset, word offset and index are removed.
   function automatic int unsigned tag_bits_for(input int unsigned num_sets,
                                                input int unsigned block_words);
      return 32 - BYTE_OFFSET_BITS - $clog2(num_sets) - $clog2(block_words);
   endfunction

endpackage

// File: rtl/data_cache_line_store.sv
// Tag, valid, dirty and data arrays for the data cache.
// Reads are combinational by index; all writes are synchronous.
// Valid and dirty bits clear asynchronously; tags and data are never reset.
module cache_line_store
   import data_cache_pkg::*;
#(
   parameter int unsigned NUM_SETS    = 16,
   parameter int unsigned BLOCK_WORDS = 4,
   parameter int unsigned INDEX_BITS  = $clog2(NUM_SETS),
   parameter int unsigned OFFSET_BITS = $clog2(BLOCK_WORDS),
   parameter int unsigned TAG_BITS    = tag_bits_for(NUM_SETS, BLOCK_WORDS)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [INDEX_BITS-1:0]              index,
   output logic                               rd_valid,
   output logic                               rd_dirty,
   output logic [TAG_BITS-1:0]                rd_tag,
   output logic [WORD_BITS*BLOCK_WORDS-1:0]   rd_line,
   input  logic                               word_we,
   input  logic [OFFSET_BITS-1:0]             word_offset,
   input  logic [WORD_BITS-1:0]               word_data,
   input  logic                               line_we,
   input  logic [TAG_BITS-1:0]                line_tag,
   input  logic [WORD_BITS*BLOCK_WORDS-1:0]   line_data,
   input  logic                               clean_we
);

   logic [TAG_BITS-1:0]  tag_mem  [NUM_SETS];
   logic [WORD_BITS-1:0] data_mem [NUM_SETS][BLOCK_WORDS];
   logic [NUM_SETS-1:0]  valid;
   logic [NUM_SETS-1:0]  dirty;

   // Combinational read of the indexed line.
   always_comb begin
      rd_valid = valid[index];
      rd_dirty = dirty[index];
      rd_tag   = tag_mem[index];
      rd_line  = '0;
      for (int unsigned w = 0; w < BLOCK_WORDS; w++) begin
         rd_line[w*WORD_BITS +: WORD_BITS] = data_mem[index][w];
      end
   end

   // Valid/dirty bookkeeping; a refill leaves the line clean, a store dirties it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= '0;
         dirty <= '0;
      end else if (line_we) begin
         valid[index] <= 1'b1;
         dirty[index] <= 1'b0;
      end else if (word_we) begin
         dirty[index] <= 1'b1;
      end else if (clean_we) begin
         dirty[index] <= 1'b0;
      end
   end

   // Tag and data writes: whole-line refill or single-word store.
   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_mem[index] <= line_tag;
         for (int unsigned w = 0; w < BLOCK_WORDS; w++) begin
            data_mem[index][w] <= line_data[w*WORD_BITS +: WORD_BITS];
         end
      end else if (word_we) begin
         data_mem[index][word_offset] <= word_data;
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU
// load/store stage and a block-oriented data memory.
module data_cache
   import data_cache_pkg::*;
#(
   parameter int unsigned NUM_SETS    = 16,
   parameter int unsigned BLOCK_WORDS = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               is_input_valid,
   input  logic [31:0]                        addr,
   input  logic [31:0]                        din,
   input  logic                               mem_read,
   input  logic                               mem_write,
   output logic                               is_ready,
   output logic                               is_output_valid,
   output logic [31:0]                        dout,
   output logic                               is_hit,
   output logic                               mem_req_valid,
   input  logic                               mem_req_ready,
   output logic                               mem_req_write,
   output logic [31:0]                        mem_req_addr,
   output logic [32*BLOCK_WORDS-1:0]          mem_req_wdata,
   input  logic                               mem_resp_valid,
   input  logic [32*BLOCK_WORDS-1:0]          mem_resp_rdata
);

   localparam int unsigned INDEX_BITS  = $clog2(NUM_SETS);
   localparam int unsigned OFFSET_BITS = $clog2(BLOCK_WORDS);
   localparam int unsigned TAG_BITS    = tag_bits_for(NUM_SETS, BLOCK_WORDS);
   localparam int unsigned LINE_BITS   = WORD_BITS * BLOCK_WORDS;

   state_t state, next_state;

   // Latched request: word address (byte offset dropped), store data, kind.
   logic [29:0]            req_waddr;
   logic [31:0]            req_din;
   logic                   req_write;
   logic                   req_access;
   logic                   miss_flag;

   logic [OFFSET_BITS-1:0] req_offset;
   logic [INDEX_BITS-1:0]  req_index;
   logic [TAG_BITS-1:0]    req_tag;

   logic                   rd_valid, rd_dirty;
   logic [TAG_BITS-1:0]    rd_tag;
   logic [LINE_BITS-1:0]   rd_line;
   logic [31:0]            hit_word;
   logic                   hit;

   logic                   accept;
   logic                   word_we, line_we, clean_we;
   logic                   load_wb, load_alloc, drop_req, set_miss;

   logic                   byte_offset_unused;
   assign byte_offset_unused = ^addr[1:0];

   assign req_offset = req_waddr[OFFSET_BITS-1:0];
   assign req_index  = req_waddr[OFFSET_BITS +: INDEX_BITS];
   assign req_tag    = req_waddr[29 -: TAG_BITS];

   cache_line_store #(
      .NUM_SETS    (NUM_SETS),
      .BLOCK_WORDS (BLOCK_WORDS)
   ) u_store (
      .clk         (clk),
      .reset       (reset),
      .index       (req_index),
      .rd_valid    (rd_valid),
      .rd_dirty    (rd_dirty),
      .rd_tag      (rd_tag),
      .rd_line     (rd_line),
      .word_we     (word_we),
      .word_offset (req_offset),
      .word_data   (req_din),
      .line_we     (line_we),
      .line_tag    (req_tag),
      .line_data   (mem_resp_rdata),
      .clean_we    (clean_we)
   );

   // Tag compare and selection of the requested word from the indexed line.
   always_comb begin
      hit      = rd_valid && (rd_tag == req_tag);
      hit_word = '0;
      for (int unsigned w = 0; w < BLOCK_WORDS; w++) begin
         if (req_offset == w[OFFSET_BITS-1:0]) begin
            hit_word = rd_line[w*WORD_BITS +: WORD_BITS];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode, CPU-side outputs and array/memory-request strobes.
   always_comb begin
      next_state      = state;
      is_ready        = 1'b0;
      is_output_valid = 1'b0;
      is_hit          = 1'b0;
      dout            = '0;
      accept          = 1'b0;
      word_we         = 1'b0;
      line_we         = 1'b0;
      clean_we        = 1'b0;
      load_wb         = 1'b0;
      load_alloc      = 1'b0;
      drop_req        = 1'b0;
      set_miss        = 1'b0;
      unique case (state)
         ST_IDLE: begin
            is_ready = 1'b1;
            if (is_input_valid) begin
               accept     = 1'b1;
               next_state = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (!req_access || hit) begin
               is_output_valid = 1'b1;
               is_hit          = !miss_flag;
               word_we         = req_write;
               if (req_access && !req_write) begin
                  dout = hit_word;
               end
               next_state = ST_IDLE;
            end else if (rd_valid && rd_dirty) begin
               set_miss   = 1'b1;
               load_wb    = 1'b1;
               next_state = ST_WRITE_BACK;
            end else begin
               set_miss   = 1'b1;
               load_alloc = 1'b1;
               next_state = ST_ALLOCATE;
            end
         end
         ST_WRITE_BACK: begin
            if (mem_req_valid && mem_req_ready) begin
               clean_we   = 1'b1;
               load_alloc = 1'b1;
               next_state = ST_ALLOCATE;
            end
         end
         ST_ALLOCATE: begin
            if (mem_req_valid && mem_req_ready) begin
               drop_req   = 1'b1;
               next_state = ST_WAIT_FILL;
            end
         end
         ST_WAIT_FILL: begin
            if (mem_resp_valid) begin
               line_we    = 1'b1;
               next_state = ST_LOOKUP;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Request latches; the miss flag survives the refill so the replay reports a miss.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_waddr  <= '0;
         req_din    <= '0;
         req_write  <= 1'b0;
         req_access <= 1'b0;
         miss_flag  <= 1'b0;
      end else if (accept) begin
         req_waddr  <= addr[31:2];
         req_din    <= din;
         req_write  <= mem_write;
         req_access <= mem_read | mem_write;
         miss_flag  <= 1'b0;
      end else if (set_miss) begin
         miss_flag  <= 1'b1;
      end
   end

   // Registered memory request; only reloaded on state changes, so it is held while stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
      end else if (load_wb) begin
         mem_req_valid <= 1'b1;
         mem_req_write <= 1'b1;
         mem_req_addr  <= {rd_tag, req_index, {(OFFSET_BITS+BYTE_OFFSET_BITS){1'b0}}};
         mem_req_wdata <= rd_line;
      end else if (load_alloc) begin
         mem_req_valid <= 1'b1;
         mem_req_write <= 1'b0;
         mem_req_addr  <= {req_tag, req_index, {(OFFSET_BITS+BYTE_OFFSET_BITS){1'b0}}};
      end else if (drop_req) begin
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: stimulus pushes expected completions,
// a monitor pops and compares on every is_output_valid pulse, and a
// behavioural memory answers block requests.
module tb_data_cache;

   localparam int unsigned NS = 16;
   localparam int unsigned BW = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              is_input_valid = 1'b0;
   logic [31:0]       addr = '0;
   logic [31:0]       din = '0;
   logic              mem_read = 1'b0;
   logic              mem_write = 1'b0;
   logic              is_ready;
   logic              is_output_valid;
   logic [31:0]       dout;
   logic              is_hit;
   logic              mem_req_valid;
   logic              mem_req_ready = 1'b0;
   logic              mem_req_write;
   logic [31:0]       mem_req_addr;
   logic [32*BW-1:0]  mem_req_wdata;
   logic              mem_resp_valid = 1'b0;
   logic [32*BW-1:0]  mem_resp_rdata = '0;

   always #5 clk = ~clk;

   data_cache #(.NUM_SETS(NS), .BLOCK_WORDS(BW)) dut (
      .clk             (clk),
      .reset           (reset),
      .is_input_valid  (is_input_valid),
      .addr            (addr),
      .din             (din),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .is_ready        (is_ready),
      .is_output_valid (is_output_valid),
      .dout            (dout),
      .is_hit          (is_hit),
      .mem_req_valid   (mem_req_valid),
      .mem_req_ready   (mem_req_ready),
      .mem_req_write   (mem_req_write),
      .mem_req_addr    (mem_req_addr),
      .mem_req_wdata   (mem_req_wdata),
      .mem_resp_valid  (mem_resp_valid),
      .mem_resp_rdata  (mem_resp_rdata)
   );

   typedef struct {
      logic [31:0] a;
      logic        is_load;
      logic [31:0] exp_dout;
      logic        chk_hit;
      logic        exp_hit;
      int unsigned exp_lat;
      int unsigned acc_cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out", name);
   endtask

   // ---------------- memory models ----------------
   logic [31:0] dram [int unsigned];   // memory-side contents
   logic [31:0] refm [int unsigned];   // CPU-visible reference

   function automatic logic [31:0] init_word(input int unsigned k);
      return 32'hC0DE_0000 | k;
   endfunction

   function automatic logic [31:0] dram_rd(input int unsigned k);
      return dram.exists(k) ? dram[k] : init_word(k);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      int unsigned k = a >> 2;
      return refm.exists(k) ? refm[k] : init_word(k);
   endfunction

   int unsigned ready_delay = 0;
   int unsigned resp_delay  = 1;
   int unsigned wr_hs = 0, rd_hs = 0, req_seen = 0;
   logic [31:0] last_wr_addr = '0, last_rd_addr = '0;

   // Memory responder: ready after ready_delay stalled cycles, read data resp_delay cycles later.
   initial begin : responder
      int unsigned wait_cnt = 0;
      int unsigned resp_timer = 0;
      logic [31:0] resp_addr = '0;
      logic        hs_write = 1'b0;
      logic [31:0] hs_addr = '0;
      logic [32*BW-1:0] hs_wdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req_valid) req_seen++;
         if (mem_resp_valid) mem_resp_valid = 1'b0;
         if (resp_timer > 0) begin
            resp_timer--;
            if (resp_timer == 0) begin
               for (int w = 0; w < BW; w++)
                  mem_resp_rdata[w*32 +: 32] = dram_rd((resp_addr >> 2) + w);
               mem_resp_valid = 1'b1;
            end
         end
         if (mem_req_ready) begin
            mem_req_ready = 1'b0;
            if (hs_write) begin
               for (int w = 0; w < BW; w++)
                  dram[(hs_addr >> 2) + w] = hs_wdata[w*32 +: 32];
               wr_hs++;
               last_wr_addr = hs_addr;
            end else begin
               rd_hs++;
               last_rd_addr = hs_addr;
               resp_addr    = hs_addr;
               resp_timer   = resp_delay;
            end
         end else if (reset && mem_req_valid) begin
            if (wait_cnt >= ready_delay) begin
               mem_req_ready = 1'b1;
               hs_write = mem_req_write;
               hs_addr  = mem_req_addr;
               hs_wdata = mem_req_wdata;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Monitor: every completion pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (reset && is_output_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got dout %0h expected no completion", dout);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.is_load) chk($sformatf("dout@%0h", mon_e.a), dout, mon_e.exp_dout);
            if (mon_e.chk_hit) chk($sformatf("is_hit@%0h", mon_e.a), is_hit, mon_e.exp_hit);
            if (mon_e.exp_lat != 0)
               chk($sformatf("latency@%0h", mon_e.a), cyc - mon_e.acc_cyc + 1, mon_e.exp_lat);
         end
      end
   end

   // Issue one request; use_ref selects the reference model over the given constant.
   task automatic cpu_req(input logic [31:0] a, input logic [31:0] d, input logic rd,
                          input logic wr, input logic use_ref, input logic [31:0] exp_d,
                          input logic chk_hit, input logic exp_hit, input int unsigned exp_lat);
      exp_t e;
      int unsigned t = 0;
      @(negedge clk);
      addr = a; din = d; mem_read = rd; mem_write = wr; is_input_valid = 1'b1;
      while (!is_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!is_ready) begin
         fail_now("accept");
         is_input_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      is_input_valid = 1'b0;
      e.a        = a;
      e.is_load  = rd & ~wr;
      e.exp_dout = use_ref ? ref_rd(a) : exp_d;
      e.chk_hit  = chk_hit;
      e.exp_hit  = exp_hit;
      e.exp_lat  = exp_lat;
      e.acc_cyc  = cyc;
      if (wr) refm[a >> 2] = d;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      int unsigned t = 0;
      @(negedge clk);
      while (!(sb.size() == 0 && is_ready) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) begin
         fail_now("completion");
         sb.delete();
      end
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

   initial begin : stim
      int unsigned wr0, rd0, seen0, t;
      logic [31:0] h_addr;
      logic [32*BW-1:0] h_wdata;
      logic [31:0] a;
      logic [31:0] d;

      for (int i = 0; i < 4; i++) begin
         dram[16 + i] = i + 1;
         refm[16 + i] = i + 1;
      end

      // Reset state.
      #12;
      chk("rst_output_valid", is_output_valid, 1'b0);
      chk("rst_is_hit", is_hit, 1'b0);
      chk("rst_mem_req_valid", mem_req_valid, 1'b0);
      chk("rst_mem_req_write", mem_req_write, 1'b0);
      chk("rst_dout", dout, 32'h0);
      chk("rst_mem_req_addr", mem_req_addr, 32'h0);
      chk("rst_is_ready", is_ready, 1'b1);
      @(negedge clk);
      reset = 1'b1;

      // Cold read miss, then a hit in the same line.
      wr0 = wr_hs; rd0 = rd_hs;
      cpu_req(32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 1'b0, 0);
      wait_idle();
      chk("cold_alloc_addr", last_rd_addr, 32'h40);
      chk("cold_reads", rd_hs - rd0, 1);
      chk("cold_no_writeback", wr_hs - wr0, 0);
      cpu_req(32'h44, 32'h0, 1'b1, 1'b0, 1'b0, 32'h2, 1'b1, 1'b1, 1);
      wait_idle();

      // Write hit: no memory traffic.
      seen0 = req_seen;
      cpu_req(32'h48, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
      wait_idle();
      chk("store_hit_no_mem_req", req_seen - seen0, 0);

      // Conflict miss on a dirty line, memory stalling the write-back.
      ready_delay = 5;
      wr0 = wr_hs;
      cpu_req(32'h440, 32'h0, 1'b1, 1'b0, 1'b0, 32'hC0DE0110, 1'b1, 1'b0, 0);
      t = 0;
      while (!mem_req_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!mem_req_valid) fail_now("wb_request");
      h_addr  = mem_req_addr;
      h_wdata = mem_req_wdata;
      chk("wb_is_write", mem_req_write, 1'b1);
      chk("wb_addr", h_addr, 32'h40);
      chk("wb_word0", h_wdata[31:0], 32'h1);
      chk("wb_word1", h_wdata[63:32], 32'h2);
      chk("wb_word2", h_wdata[95:64], 32'hDEADBEEF);
      chk("wb_word3", h_wdata[127:96], 32'h4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("wb_hold_valid", mem_req_valid, 1'b1);
         chk("wb_hold_write", mem_req_write, 1'b1);
         chk("wb_hold_addr", mem_req_addr, h_addr);
         chk("wb_hold_wdata", mem_req_wdata, h_wdata);
      end
      wait_idle();
      ready_delay = 0;
      chk("wb_count", wr_hs - wr0, 1);
      chk("wb_last_addr", last_wr_addr, 32'h40);
      chk("refill_addr", last_rd_addr, 32'h440);
      // Written-back store comes back through a fresh refill.
      cpu_req(32'h48, 32'h0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 0);
      wait_idle();

      // Reset while waiting for the fill.
      resp_delay = 8;
      rd0 = rd_hs;
      @(negedge clk);
      addr = 32'h80; mem_read = 1'b1; mem_write = 1'b0; is_input_valid = 1'b1;
      @(posedge clk);
      #1;
      is_input_valid = 1'b0;
      t = 0;
      while (rd_hs == rd0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (rd_hs == rd0) fail_now("fill_request");
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_output_valid", is_output_valid, 1'b0);
      chk("abort_is_hit", is_hit, 1'b0);
      chk("abort_dout", dout, 32'h0);
      chk("abort_mem_req_valid", mem_req_valid, 1'b0);
      chk("abort_mem_req_write", mem_req_write, 1'b0);
      chk("abort_mem_req_addr", mem_req_addr, 32'h0);
      chk("abort_is_ready", is_ready, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      seen0 = req_seen;
      repeat (15) @(negedge clk);
      chk("abort_idle_no_req", req_seen - seen0, 0);
      resp_delay = 1;
      cpu_req(32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 1'b0, 0);
      wait_idle();

      // Read and write together is a store.
      cpu_req(32'h80, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 0);
      cpu_req(32'h80, 32'h0, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b1, 1);
      wait_idle();

      // No-op request completes as a hit without touching memory.
      seen0 = req_seen;
      cpu_req(32'h900, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
      wait_idle();
      chk("noop_no_mem_req", req_seen - seen0, 0);

      // Mixed load/store stream against the flat reference.
      for (int i = 0; i < 60; i++) begin
         ready_delay = $urandom_range(0, 2);
         resp_delay  = $urandom_range(1, 3);
         a = 32'($urandom_range(0, 255)) << 2;
         d = $urandom;
         if ($urandom_range(0, 1) == 1)
            cpu_req(a, d, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 0);
         else
            cpu_req(a, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 0);
      end
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
